lcd_spi_tx: RTL and testbench

LCD_SPI_TX -- requirements
Module: lcd_spi_tx

---
 rtl/lcd_spi_tx.sv | 154 +++++++++++++++
 tb/tb_lcd_spi_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_tx.sv
// Serial LCD transmitter: panel reset sequencing, a 4-entry {dc,data} FIFO,
// and an MSB-first SPI-style shifter with a programmable half-period.
module lcd_spi_tx #(
    parameter int HALF_DIV = 74,
    parameter int RST_CYC  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_dc,
    output logic       in_ready,
    output logic       lcd_rst,
    output logic       lcd_ce,
    output logic       lcd_dc,
    output logic       lcd_clk,
    output logic       lcd_din,
    output logic       tx_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        INIT_LOW,
        INIT_WAIT,
        IDLE,
        SHIFT_LO,
        SHIFT_HI
    } state_t;

    localparam logic [7:0]  HALF_LAST = 8'(HALF_DIV - 1);
    localparam logic [15:0] RST_LAST  = 16'(RST_CYC - 1);

    state_t      state;
    logic [15:0] rst_cnt;
    logic [7:0]  half_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;

    logic [8:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [8:0]  head;
    logic        push;
    logic        pop;
    logic        byte_end;

    assign in_ready = !rst && (count != 3'd4);
    assign push     = in_valid && in_ready;
    assign head     = fifo_mem[rd_ptr];
    assign byte_end = (state == SHIFT_HI) && (half_cnt == HALF_LAST) && (bit_cnt == 3'd7);
    assign pop      = !rst && (count != 3'd0) && ((state == IDLE) || byte_end);
    assign busy     = (state != IDLE) || (count != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {in_dc, in_data};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT_LOW;
            rst_cnt  <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            lcd_rst  <= 1'b0;
            lcd_ce   <= 1'b1;
            lcd_clk  <= 1'b0;
            lcd_din  <= 1'b0;
            lcd_dc   <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                INIT_LOW: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt <= '0;
                        lcd_rst <= 1'b1;
                        state   <= INIT_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 16'd1;
                    end
                end
                INIT_WAIT: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 16'd1;
                    end
                end
                SHIFT_LO: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        lcd_clk  <= 1'b1;
                        state    <= SHIFT_HI;
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        lcd_clk  <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            tx_done <= 1'b1;
                            lcd_ce  <= 1'b1;
                            lcd_din <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {shreg[5:0], 1'b0};
                            lcd_din <= shreg[6];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                default: state <= state;
            endcase
            // A pop (from IDLE or at byte end) overrides the case above and
            // starts the next byte straight in SHIFT_LO with lcd_ce kept low.
            if (pop) begin
                shreg    <= head[6:0];
                lcd_din  <= head[7];
                lcd_dc   <= head[8];
                lcd_ce   <= 1'b0;
                lcd_clk  <= 1'b0;
                half_cnt <= '0;
                bit_cnt  <= '0;
                state    <= SHIFT_LO;
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Randomized and directed bench for lcd_spi_tx; expected pin behaviour is
// derived from byte start times and a queue of accepted bytes.
module tb_lcd_spi_tx;

    localparam int H        = 4;
    localparam int R        = 8;
    localparam int BYTE_CYC = 16 * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_dc = 1'b0;
    logic       in_ready, lcd_rst, lcd_ce, lcd_dc, lcd_clk, lcd_din, tx_done, busy;

    lcd_spi_tx #(.HALF_DIV(H), .RST_CYC(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_dc    (in_dc),
        .in_ready (in_ready),
        .lcd_rst  (lcd_rst),
        .lcd_ce   (lcd_ce),
        .lcd_dc   (lcd_dc),
        .lcd_clk  (lcd_clk),
        .lcd_din  (lcd_din),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pos = cycles since the current byte was popped (-1 when none).
    logic [8:0] q[$];
    logic [8:0] cur = '0;
    int         pos = -1;
    bit         in_init = 1'b1;
    int         init_t = 0;
    bit         m_done = 1'b0;
    bit         m_pushed = 1'b0;
    logic       m_dc = 1'b0;
    int         m_done_cnt = 0;
    int         seen_done = 0;

    always @(posedge clk) begin
        bit can_push;
        m_pushed = 1'b0;
        m_done   = 1'b0;
        if (rst) begin
            q.delete();
            in_init = 1'b1;
            init_t  = 0;
            pos     = -1;
            m_dc    = 1'b0;
        end else begin
            can_push = in_valid && (q.size() < 4);
            if (in_init) begin
                init_t++;
                if (init_t >= 2 * R) in_init = 1'b0;
            end else if (pos < 0) begin
                if (q.size() > 0) begin
                    cur  = q.pop_front();
                    m_dc = cur[8];
                    pos  = 0;
                end
            end else if (pos == BYTE_CYC - 1) begin
                m_done = 1'b1;
                m_done_cnt++;
                if (q.size() > 0) begin
                    cur  = q.pop_front();
                    m_dc = cur[8];
                    pos  = 0;
                end else begin
                    pos = -1;
                end
            end else begin
                pos++;
            end
            if (can_push) begin
                q.push_back({in_dc, in_data});
                m_pushed = 1'b1;
            end
        end
    end

    task automatic compare_outputs();
        logic e_din;
        int   bit_idx;
        e_din = 1'b0;
        if (pos >= 0) begin
            bit_idx = 7 - pos / (2 * H);
            e_din   = cur[bit_idx];
        end
        check("lcd_rst",  32'(lcd_rst),  32'(!(in_init && init_t < R)));
        check("lcd_ce",   32'(lcd_ce),   32'(pos < 0));
        check("lcd_clk",  32'(lcd_clk),  32'((pos >= 0) ? ((pos / H) % 2) : 0));
        check("lcd_din",  32'(lcd_din),  32'(e_din));
        check("lcd_dc",   32'(lcd_dc),   32'(m_dc));
        check("tx_done",  32'(tx_done),  32'(m_done));
        check("busy",     32'(busy),     32'(in_init || q.size() != 0 || pos >= 0));
        check("in_ready", 32'(in_ready), 32'(!rst && q.size() < 4));
        if (tx_done) seen_done++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic send(input logic [7:0] d, input logic dc);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_dc    = dc;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (m_pushed) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!in_init && pos < 0 && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("idle_timeout", 32'(ok), 32'(1));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        // Init sequence with bytes queued during panel reset.
        do_reset(3);
        send(8'h3A, 1'b0);
        send(8'hC5, 1'b1);
        wait_idle();

        // Single command byte.
        send(8'h21, 1'b0);
        wait_idle();

        // Five bytes back-to-back.
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i * 8'h11), i[0]);
        wait_idle();

        // Command then data.
        send(8'h0C, 1'b0);
        send(8'hFF, 1'b1);
        wait_idle();

        // Reset after the 3rd lcd_clk rising edge of a byte.
        send(8'hA5, 1'b1);
        for (int i = 0; i < 200 && pos != 5 * H; i++) tick();
        check("midbyte_reached", 32'(pos), 32'(5 * H));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_idle();

        // Six offers during INIT_LOW: only the first four are accepted.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_dc    = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            in_valid = ($urandom_range(0, 5) == 0);
            in_data  = 8'($urandom);
            in_dc    = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        wait_idle();

        check("done_total", 32'(seen_done), 32'(m_done_cnt));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
